// File: rtl/word_aligner_10b.sv
// word_aligner_10b
// Finds K28.5 commas in a raw 10-bit deserializer stream and re-frames the
// stream so that each output word is one complete 8b10b symbol.
//
// A 20-bit window {previous word, current word} is searched for a comma at
// each of the ten bit offsets. A hunt/verify/locked state machine decides
// which offset is trusted, and words leave through a one-cycle output
// register.
//
// Parameters
//   LOCK_CNT  consecutive same-offset commas needed to lock (1..7)
//   LOSS_CNT  consecutive wrong-offset commas that drop lock (1..7)
// Ports
//   clk           parallel-domain clock, rising edge
//   rst           asynchronous active-high reset
//   data_in       raw unaligned word, bit 9 received first
//   valid_in      data_in qualifier
//   data_out      aligned symbol for the 8b10b decoder
//   valid_out     data_out qualifier (only while locked)
//   comma_out     data_out is K28.5 (either disparity)
//   locked        alignment state is LOCKED
//   align_offset  current alignment offset, 0..9
//   realign       one-cycle pulse after align_offset changed
module word_aligner_10b #(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] data_in,
  input  logic       valid_in,
  output logic [9:0] data_out,
  output logic       valid_out,
  output logic       comma_out,
  output logic       locked,
  output logic [3:0] align_offset,
  output logic       realign
);

  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;
  // Narrowed copies so the threshold compares stay 4 bits wide.
  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [9:0] prev_reg;
  logic [3:0] offset_reg, offset_next;
  logic [2:0] cnt_reg, cnt_next;
  logic [2:0] miss_reg, miss_next;

  logic [19:0] window;
  logic [9:0]  cand [10];
  logic [9:0]  match;
  logic [3:0]  hit_k;
  logic        hit_any;
  logic [9:0]  sel_word;
  logic        sel_comma;

  assign window = {prev_reg, data_in};

  // Candidate k starts k bits into the older word.
  for (genvar gi = 0; gi < 10; gi++) begin : g_cand
    assign cand[gi]  = window[19-gi -: 10];
    assign match[gi] = (cand[gi] == K28_5_RDN) || (cand[gi] == K28_5_RDP);
  end

  assign hit_any = |match;

  // Lowest matching offset wins: scan downwards so the last write is lowest.
  always_comb begin
    hit_k = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (match[i]) hit_k = 4'(i);
    end
  end

  always_comb begin
    state_next  = state_reg;
    offset_next = offset_reg;
    cnt_next    = cnt_reg;
    miss_next   = miss_reg;
    if (valid_in) begin
      case (state_reg)
        HUNT: begin
          if (hit_any) begin
            offset_next = hit_k;
            cnt_next    = 3'd1;
            miss_next   = 3'd0;
            state_next  = (LOCK_N <= 4'd1) ? LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          if (hit_any) begin
            if (hit_k == offset_reg) begin
              if (cnt_reg != 3'd7) cnt_next = cnt_reg + 3'd1;
              if (({1'b0, cnt_reg} + 4'd1) >= LOCK_N) begin
                state_next = LOCKED;
                miss_next  = 3'd0;
              end
            end else begin
              // Comma moved: restart verification at the new position.
              offset_next = hit_k;
              cnt_next    = 3'd1;
            end
          end
        end
        LOCKED: begin
          // A comma at the locked offset counts as good even when a lower
          // offset also happens to match.
          if (match[offset_reg]) begin
            miss_next = 3'd0;
          end else if (hit_any) begin
            if (miss_reg != 3'd7) miss_next = miss_reg + 3'd1;
            if (({1'b0, miss_reg} + 4'd1) >= LOSS_N) begin
              state_next = HUNT;
              cnt_next   = 3'd0;
              miss_next  = 3'd0;
            end
          end
        end
        default: begin
          state_next = HUNT;
          cnt_next   = 3'd0;
          miss_next  = 3'd0;
        end
      endcase
    end
  end

  // The word leaving this cycle uses the offset chosen this cycle, so the
  // comma that triggered a realignment is itself emitted aligned.
  assign sel_word  = cand[offset_next];
  assign sel_comma = (sel_word == K28_5_RDN) || (sel_word == K28_5_RDP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= HUNT;
      prev_reg   <= '0;
      offset_reg <= '0;
      cnt_reg    <= '0;
      miss_reg   <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      comma_out  <= 1'b0;
      locked     <= 1'b0;
      realign    <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      realign   <= 1'b0;
      if (valid_in) begin
        state_reg  <= state_next;
        prev_reg   <= data_in;
        offset_reg <= offset_next;
        cnt_reg    <= cnt_next;
        miss_reg   <= miss_next;
        data_out   <= sel_word;
        comma_out  <= sel_comma;
        valid_out  <= (state_next == LOCKED);
        locked     <= (state_next == LOCKED);
        realign    <= (offset_next != offset_reg);
      end
    end
  end

  assign align_offset = offset_reg;

endmodule

// File: tb/tb_word_aligner_10b.sv
// Bench for word_aligner_10b: a serial bit-stream builder produces framed
// words at chosen offsets, a bit-queue reference model predicts each
// cycle's outputs into a scoreboard, and a monitor compares every cycle.
module tb_word_aligner_10b;

  localparam int LOCK_CNT = 3;
  localparam int LOSS_CNT = 4;
  localparam logic [9:0] K_N = 10'b0011111010;
  localparam logic [9:0] K_P = 10'b1100000101;
  localparam logic [9:0] D_A = 10'b1010101010;
  localparam logic [9:0] D_B = 10'b0101010101;
  localparam logic [9:0] D_C = 10'b0110001011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] data_in = '0;
  logic       valid_in = 1'b0;
  logic [9:0] data_out;
  logic       valid_out, comma_out, locked, realign;
  logic [3:0] align_offset;

  word_aligner_10b #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .data_out(data_out), .valid_out(valid_out), .comma_out(comma_out),
    .locked(locked), .align_offset(align_offset), .realign(realign)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] d;
    logic       c;
    logic       v;
    logic       l;
    logic [3:0] o;
    logic       r;
    logic       vin;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   realign_seen = 0;
  int   txn = 0;
  int   gap_en = 0;

  // Reference model: a 20-bit history of received bits, oldest first.
  bit   hist[$];
  int   m_mode;   // 0 hunt, 1 verify, 2 locked
  int   m_run, m_miss, m_off;
  exp_t m_out;
  bit   txq[$];   // serial stream waiting to be framed into words

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic is_k(logic [9:0] w);
    return (w == K_N) || (w == K_P);
  endfunction

  function automatic logic [9:0] cand_of(int k);
    logic [9:0] w;
    w = '0;
    for (int i = 0; i < 10; i++) w = {w[8:0], logic'(hist[k+i])};
    return w;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 20; i++) hist.push_back(1'b0);
    m_mode = 0; m_run = 0; m_miss = 0; m_off = 0;
    m_out = '0;
  endtask

  task automatic model_word(logic [9:0] d);
    int hit, old_off;
    logic [9:0] c;
    for (int i = 9; i >= 0; i--) hist.push_back(d[i]);
    while (hist.size() > 20) void'(hist.pop_front());
    hit = -1;
    for (int k = 0; k < 10; k++) if (hit < 0 && is_k(cand_of(k))) hit = k;
    old_off = m_off;
    if (m_mode == 0) begin
      if (hit >= 0) begin
        m_off = hit; m_run = 1;
        m_mode = (LOCK_CNT == 1) ? 2 : 1;
      end
    end else if (m_mode == 1) begin
      if (hit >= 0) begin
        if (hit == m_off) begin
          m_run = (m_run < 7) ? m_run + 1 : 7;
          if (m_run >= LOCK_CNT) m_mode = 2;
        end else begin
          m_off = hit; m_run = 1;
        end
      end
    end else begin
      if (is_k(cand_of(m_off))) m_miss = 0;
      else if (hit >= 0) begin
        m_miss = (m_miss < 7) ? m_miss + 1 : 7;
        if (m_miss >= LOSS_CNT) begin
          m_mode = 0; m_run = 0; m_miss = 0;
        end
      end
    end
    c = cand_of(m_off);
    m_out.d = c;
    m_out.c = is_k(c);
    m_out.v = (m_mode == 2);
    m_out.l = (m_mode == 2);
    m_out.o = 4'(m_off);
    m_out.r = (m_off != old_off);
    m_out.vin = 1'b1;
  endtask

  // One clock cycle of stimulus; the expectation for the following edge is
  // queued for the monitor.
  task automatic step(bit r, bit v, logic [9:0] d);
    @(negedge clk);
    rst = r; valid_in = v; data_in = d;
    if (r) model_reset();
    else if (v) model_word(d);
    else begin
      m_out.v = 1'b0; m_out.r = 1'b0; m_out.vin = 1'b0;
    end
    sb.push_back(m_out);
  endtask

  task automatic send_word(logic [9:0] w);
    if (gap_en != 0 && $urandom_range(0, 2) == 0)
      repeat ($urandom_range(1, 5)) step(1'b0, 1'b0, 10'($urandom));
    step(1'b0, 1'b1, w);
  endtask

  task automatic flush();
    logic [9:0] w;
    while (txq.size() >= 10) begin
      w = '0;
      for (int i = 0; i < 10; i++) w = {w[8:0], logic'(txq.pop_front())};
      send_word(w);
    end
  endtask

  task automatic put_sym(logic [9:0] s);
    for (int i = 9; i >= 0; i--) txq.push_back(s[i]);
    flush();
  endtask

  // Alternating filler bits slip the stream framing by n bit positions.
  task automatic put_junk(int n);
    for (int i = 0; i < n; i++) txq.push_back(bit'(i % 2));
    flush();
  endtask

  function automatic logic [9:0] rand_d();
    case ($urandom_range(0, 2))
      0: return D_A;
      1: return D_B;
      default: return D_C;
    endcase
  endfunction

  task automatic commas(int n);
    for (int i = 0; i < n; i++) begin
      put_sym(K_N);
      put_sym(rand_d());
    end
  endtask

  task automatic do_reset(int cycles);
    repeat (cycles) step(1'b1, 1'b0, '0);
    txq.delete();
    realign_seen = 0;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: pops one expectation per clock edge and compares all outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (realign === 1'b1) realign_seen++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("data_out", 16'(data_out), 16'(e.d));
        chk("comma_out", 16'(comma_out), 16'(e.c));
        chk("valid_out", 16'(valid_out), 16'(e.v));
        chk("locked", 16'(locked), 16'(e.l));
        chk("align_offset", 16'(align_offset), 16'(e.o));
        chk("realign", 16'(realign), 16'(e.r));
        if (e.vin) begin
          txn++;
          $display("txn %0d: data_out=%b comma=%0d valid=%0d locked=%0d offset=%0d realign=%0d",
                   txn, data_out, comma_out, valid_out, locked, align_offset, realign);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    m_out = '0;

    // Lock at offset 3 with data words between commas.
    do_reset(3);
    put_junk(3);
    commas(2);
    put_sym(K_N);
    put_sym(rand_d());
    settle();
    chk("p1_locked", 16'(locked), 16'd1);
    chk("p1_offset", 16'(align_offset), 16'd3);
    chk("p1_lock_word", 16'(data_out), 16'(K_N));
    chk("p1_lock_comma", 16'(comma_out), 16'd1);
    chk("p1_lock_valid", 16'(valid_out), 16'd1);
    chk("p1_realigns", 16'(realign_seen), 16'd1);

    // Four commas at offset 7 drop lock; three more relock there.
    put_junk(4);
    commas(4);
    settle();
    chk("p2_lost", 16'(locked), 16'd0);
    chk("p2_kept_offset", 16'(align_offset), 16'd3);
    commas(3);
    settle();
    chk("p2_relocked", 16'(locked), 16'd1);
    chk("p2_offset", 16'(align_offset), 16'd7);

    // Three misses, one good comma, three more misses: still locked.
    put_junk(2);
    commas(3);
    put_junk(8);
    commas(1);
    put_junk(2);
    commas(3);
    settle();
    chk("p3_still_locked", 16'(locked), 16'd1);
    put_junk(8);
    commas(1);

    // Verify at offset 2 redirected to offset 5, with valid_in gaps.
    gap_en = 1;
    do_reset(2);
    put_junk(2);
    commas(1);
    settle();
    chk("p4_offset2", 16'(align_offset), 16'd2);
    put_junk(3);
    commas(2);
    settle();
    chk("p4_not_yet", 16'(locked), 16'd0);
    chk("p4_offset5", 16'(align_offset), 16'd5);
    commas(1);
    settle();
    chk("p4_locked", 16'(locked), 16'd1);
    chk("p4_realigns", 16'(realign_seen), 16'd2);

    // Random symbol stream at a random offset with gaps.
    do_reset(2);
    put_junk($urandom_range(0, 9));
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0: put_sym(K_N);
        1: put_sym(K_P);
        default: put_sym(rand_d());
      endcase
    end

    // Asynchronous reset while locked, then a full relock.
    gap_en = 0;
    commas(3);
    settle();
    chk("p6_locked", 16'(locked), 16'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    valid_in = 1'b0;
    #1;
    chk("arst_data_out", 16'(data_out), 16'd0);
    chk("arst_valid_out", 16'(valid_out), 16'd0);
    chk("arst_comma_out", 16'(comma_out), 16'd0);
    chk("arst_locked", 16'(locked), 16'd0);
    chk("arst_offset", 16'(align_offset), 16'd0);
    chk("arst_realign", 16'(realign), 16'd0);
    model_reset();
    sb.push_back(m_out);
    step(1'b1, 1'b0, '0);
    commas(2);
    settle();
    chk("p6_two_commas", 16'(locked), 16'd0);
    commas(1);
    settle();
    chk("p6_relocked", 16'(locked), 16'd1);

    // Commas at offsets 0 and 9 in the same window: lowest offset wins.
    do_reset(2);
    step(1'b0, 1'b1, 10'b0011111010);
    step(1'b0, 1'b1, 10'b0111110100);
    settle();
    chk("lowk_offset", 16'(align_offset), 16'd0);
    chk("lowk_word", 16'(data_out), 16'(K_N));

    // Unstructured random words and valid pattern.
    do_reset(1);
    for (int n = 0; n < 400; n++)
      step(1'b0, bit'($urandom_range(0, 3) != 0), 10'($urandom));

    step(1'b0, 1'b0, '0);
    repeat (3) @(posedge clk);
    #2;
    chk("sb_drained", 16'(sb.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/word_aligner_10b.md
WORD_ALIGNER_10B -- requirements
Module: word_aligner_10b

Interface
REQ-001 The block SHALL have parameter LOCK_CNT, default 3: consecutive same-offset commas needed to reach LOCKED.
REQ-002 The block SHALL have parameter LOSS_CNT, default 4: consecutive wrong-offset commas in LOCKED that force HUNT.
REQ-003 The block SHALL have port clk, input, 1 bit: the parallel-domain clock, with all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port data_in, input, 10 bits: the raw unaligned word from the deserializer, with bit 9 received first.
REQ-006 The block SHALL have port valid_in, input, 1 bit: data_in qualifier.
REQ-007 The block SHALL have port data_out, output, 10 bits: the aligned symbol to the 8b10b decoder.
REQ-008 The block SHALL have port valid_out, output, 1 bit: data_out qualifier.
REQ-009 The block SHALL have port comma_out, output, 1 bit: data_out is K28.5.
REQ-010 The block SHALL have port locked, output, 1 bit: the state is LOCKED.
REQ-011 The block SHALL have port align_offset, output, 4 bits: the current alignment offset, range 0..9.
REQ-012 The block SHALL have port realign, output, 1 bit: a one-cycle pulse when align_offset changes.

Function
REQ-013 The block SHALL hold a 10-bit prev register, loaded with data_in on each valid_in cycle.
REQ-014 The window SHALL be {prev, data_in}, 20 bits; candidate k (0..9) SHALL be window[19-k : 10-k].
REQ-015 Comma SHALL mean a candidate equal to 10'b0011111010 (K28.5 RD-) or 10'b1100000101 (K28.5 RD+).
REQ-016 Comma detection SHALL be evaluated only when valid_in=1; if several offsets match, the lowest k SHALL win (hit_k).
REQ-017 The FSM SHALL have the states HUNT, VERIFY and LOCKED; a 3-bit cnt SHALL count commas; a 3-bit miss SHALL count misses.
REQ-018 HUNT: any comma SHALL set the offset to hit_k, set cnt=1 and go to VERIFY; if LOCK_CNT=1, it SHALL go directly to LOCKED.
REQ-019 VERIFY: a comma at offset=hit_k SHALL increment cnt, and the FSM SHALL go to LOCKED when cnt+1 reaches LOCK_CNT.
REQ-020 VERIFY: a comma at a different k SHALL set the offset to hit_k and cnt=1, remaining in VERIFY.
REQ-021 VERIFY: non-comma words SHALL leave the state unchanged.
REQ-022 LOCKED: a comma at the locked offset SHALL clear miss.
REQ-023 LOCKED: a comma only at another offset SHALL increment miss; on reaching LOSS_CNT the FSM SHALL go to HUNT with cnt=0 and miss=0, keeping the offset.
REQ-024 LOCKED: non-comma words SHALL leave miss unchanged.
REQ-025 Offset effect: when an offset update occurs in a cycle, extraction in that same cycle SHALL use the new offset (hit_k), so the comma word itself is output aligned.
REQ-026 Outputs SHALL be registered with latency 1 clk: data_out/comma_out SHALL be updated on valid_in cycles only and hold otherwise.
REQ-027 valid_out SHALL be 1 for one cycle after a valid_in cycle whose next-state is LOCKED, including the transition word, and 0 otherwise.
REQ-028 comma_out SHALL equal the comma test applied to the extracted word.
REQ-029 realign SHALL pulse 1 cycle after any cycle where the offset register value changes; re-detection at an equal offset SHALL NOT pulse.
REQ-030 locked SHALL be the registered state==LOCKED.
REQ-031 valid_in=0 cycles SHALL freeze prev, the FSM, the counters and the outputs, except valid_out and realign, which SHALL go to 0.
REQ-032 Counters SHALL saturate and never wrap; LOCK_CNT and LOSS_CNT SHALL be in the range 1..7.

Reset
REQ-033 While rst=1, the state SHALL be HUNT and prev, data_out, offset, cnt and miss SHALL be 0.
REQ-034 While rst=1, valid_out, comma_out, locked and realign SHALL be 0.
REQ-035 Reset asserted mid-operation SHALL abort the lock immediately, and the first post-reset valid word SHALL be treated as in HUNT.

Verification
REQ-036 Bench SHALL cover: stream K28.5 RD- at offset 3 with D-words between, LOCK_CNT=3 -> 1 realign pulse (offset 3), locked after 3rd comma, data_out=10'b0011111010 with comma_out=1 on lock word.
REQ-037 Bench SHALL cover: locked at offset 3, then 4 commas at offset 7 -> locked drops after 4th, next comma relocks at offset 7 after 3 commas.
REQ-038 Bench SHALL cover: locked, 3 wrong-offset commas then 1 correct comma -> miss cleared, locked stays 1.
REQ-039 Bench SHALL cover: VERIFY at offset 2, comma seen at offset 5 -> offset=5, realign pulse, cnt restarts, locked after 2 more at 5.
REQ-040 Bench SHALL cover: valid_in gaps of 1-5 cycles inserted -> identical aligned output sequence, valid_out only follows valid_in.
REQ-041 Bench SHALL cover: rst pulsed while locked -> all outputs 0 asynchronously, relock requires full LOCK_CNT commas.
